exe_result_collector: RTL and testbench

Downstream stage of exe_unit_w1. Captures each (o_result, o_status) pair the execution unit produces when qualified by a valid strobe and buffers it in a small show-ahead FIFO. Drains to the consumer over a valid/ready handshake. Also keeps sticky status flags and a saturating drop counter for debug and verification.

---
 rtl/exe_result_collector.sv | 85 ++++++++
 tb/tb_exe_result_collector.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/exe_result_collector.sv
// Buffers qualified (result, status) pairs in a show-ahead FIFO with 1-cycle write-to-read latency; drains over valid/ready.
// When full and not popped, a new entry is dropped and counted; sticky status collects every valid status word.
module exe_result_collector #(
   parameter int m     = 4,
   parameter int DEPTH = 4,
   parameter int CW    = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rsn,
   input  logic                     i_valid,
   input  logic [m-1:0]             i_result,
   input  logic [3:0]               i_status,
   input  logic                     i_ready,
   input  logic                     i_clr_sticky,
   output logic                     o_valid,
   output logic [m-1:0]             o_result,
   output logic [3:0]               o_status,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [3:0]               o_sticky,
   output logic                     o_drop,
   output logic [CW-1:0]            o_drop_cnt
);
   localparam int AW   = $clog2(DEPTH);
   localparam int CNTW = AW + 1;

   logic [m+3:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          push;
   logic          pop;
   logic          drop;

   assign o_empty = (o_count == '0);
   assign o_full  = (o_count == CNTW'(DEPTH));
   assign o_valid = !o_empty;
   assign pop     = o_valid && i_ready;
   assign push    = i_valid && (!o_full || pop);
   assign drop    = i_valid && o_full && !pop;

   // Head is driven to zero while empty so stale storage never leaks out.
   assign {o_result, o_status} = o_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge i_clk) begin
      if (push) begin
         mem[wr_ptr] <= {i_result, i_status};
      end
   end

   always_ff @(posedge i_clk or negedge i_rsn) begin
      if (!i_rsn) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         o_count    <= '0;
         o_sticky   <= '0;
         o_drop     <= 1'b0;
         o_drop_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   o_count <= o_count + CNTW'(1);
            2'b01:   o_count <= o_count - CNTW'(1);
            default: o_count <= o_count;
         endcase

         o_drop <= drop;
         if (drop && (o_drop_cnt != '1)) begin
            o_drop_cnt <= o_drop_cnt + CW'(1);
         end

         // A clear coinciding with a new status keeps the new event.
         if (i_valid) begin
            o_sticky <= (i_clr_sticky ? 4'b0000 : o_sticky) | i_status;
         end else if (i_clr_sticky) begin
            o_sticky <= '0;
         end
      end
   end
endmodule

// File: tb/tb_exe_result_collector.sv
// Directed and randomized checks of exe_result_collector against a queue-based reference model.
module tb_exe_result_collector;
   localparam int M     = 4;
   localparam int DEPTH = 4;
   localparam int CW    = 8;

   logic          clk;
   logic          rsn;
   logic          valid;
   logic [M-1:0]  result;
   logic [3:0]    status;
   logic          ready;
   logic          clr_sticky;
   logic          o_valid;
   logic [M-1:0]  o_result;
   logic [3:0]    o_status;
   logic [2:0]    o_count;
   logic          o_full;
   logic          o_empty;
   logic [3:0]    o_sticky;
   logic          o_drop;
   logic [CW-1:0] o_drop_cnt;

   exe_result_collector #(.m(M), .DEPTH(DEPTH), .CW(CW)) dut (
      .i_clk(clk), .i_rsn(rsn), .i_valid(valid), .i_result(result),
      .i_status(status), .i_ready(ready), .i_clr_sticky(clr_sticky),
      .o_valid(o_valid), .o_result(o_result), .o_status(o_status),
      .o_count(o_count), .o_full(o_full), .o_empty(o_empty),
      .o_sticky(o_sticky), .o_drop(o_drop), .o_drop_cnt(o_drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: FIFO contents as a queue of {result, status}.
   logic [M+3:0] q[$];
   logic [3:0]   m_sticky;
   logic         m_drop;
   int           m_drop_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_sticky   = 4'b0;
      m_drop     = 1'b0;
      m_drop_cnt = 0;
   endtask

   task automatic model_step(input logic v, input logic [3:0] r, input logic [3:0] s,
                             input logic rdy, input logic clr);
      bit do_pop, do_push, was_full;
      was_full = (q.size() == DEPTH);
      do_pop   = (q.size() > 0) && rdy;
      do_push  = v && (!was_full || do_pop);
      m_drop   = v && was_full && !do_pop;
      if (m_drop && m_drop_cnt < (1 << CW) - 1) m_drop_cnt++;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({r, s});
      if (v) m_sticky = (clr ? 4'b0 : m_sticky) | s;
      else if (clr) m_sticky = 4'b0;
   endtask

   task automatic check_all(input string tag);
      logic [M+3:0] head;
      head = (q.size() > 0) ? q[0] : '0;
      check({tag, ".valid"},   32'(o_valid),    32'(q.size() > 0));
      check({tag, ".result"},  32'(o_result),   32'(head[M+3:4]));
      check({tag, ".status"},  32'(o_status),   32'(head[3:0]));
      check({tag, ".count"},   32'(o_count),    32'(q.size()));
      check({tag, ".full"},    32'(o_full),     32'(q.size() == DEPTH));
      check({tag, ".empty"},   32'(o_empty),    32'(q.size() == 0));
      check({tag, ".sticky"},  32'(o_sticky),   32'(m_sticky));
      check({tag, ".drop"},    32'(o_drop),     32'(m_drop));
      check({tag, ".dropcnt"}, 32'(o_drop_cnt), 32'(m_drop_cnt));
   endtask

   // Called one time unit after a rising edge; ends one time unit after the next.
   task automatic cycle(input logic v, input logic [3:0] r, input logic [3:0] s,
                        input logic rdy, input logic clr, input string tag);
      valid = v; result = r; status = s; ready = rdy; clr_sticky = clr;
      #1 check_all({tag, ".pre"});
      model_step(v, r, s, rdy, clr);
      @(posedge clk);
      #1 check_all(tag);
   endtask

   initial begin
      rsn = 1'b0; valid = 1'b0; result = '0; status = '0; ready = 1'b0; clr_sticky = 1'b0;
      model_reset();
      #2 check_all("reset");
      #4 rsn = 1'b1;

      // Single push, no consumer.
      cycle(1, 4'b1000, 4'b0010, 0, 0, "t1");
      check("t1.res8", 32'(o_result), 32'h8);
      check("t1.stat2", 32'(o_status), 32'h2);
      check("t1.cnt1", 32'(o_count), 32'd1);
      check("t1.sticky2", 32'(o_sticky), 32'h2);
      cycle(0, 0, 0, 1, 0, "t1.drain");

      // Fill, drop, drain.
      for (int i = 1; i <= 4; i++) cycle(1, 4'(i), 4'(0), 0, 0, "t2.fill");
      check("t2.full", 32'(o_full), 32'd1);
      check("t2.cnt4", 32'(o_count), 32'd4);
      cycle(1, 4'd5, 0, 0, 0, "t2.drop");
      check("t2.droppulse", 32'(o_drop), 32'd1);
      check("t2.dropcnt1", 32'(o_drop_cnt), 32'd1);
      cycle(0, 0, 0, 0, 0, "t2.idle");
      check("t2.dropend", 32'(o_drop), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         check("t2.order", 32'(o_result), 32'(i));
         cycle(0, 0, 0, 1, 0, "t2.drain");
      end
      check("t2.empty", 32'(o_empty), 32'd1);

      // Push and pop together while full.
      for (int i = 1; i <= 4; i++) cycle(1, 4'(i), 4'(0), 0, 0, "t3.fill");
      cycle(1, 4'd9, 0, 1, 0, "t3.pushpop");
      check("t3.cnt4", 32'(o_count), 32'd4);
      check("t3.nodrop", 32'(o_drop), 32'd0);
      check("t3.dropcnt", 32'(o_drop_cnt), 32'd1);
      begin
         logic [3:0] exp_order [4];
         exp_order = '{4'd2, 4'd3, 4'd4, 4'd9};
         for (int i = 0; i < 4; i++) begin
            check("t3.order", 32'(o_result), 32'(exp_order[i]));
            cycle(0, 0, 0, 1, 0, "t3.drain");
         end
      end

      // Streaming with the consumer always ready exercises pointer wrap.
      for (int i = 0; i < 10; i++) begin
         cycle(1, 4'(i), 4'(0), 1, 0, "t4.stream");
         check("t4.head", 32'(o_result), 32'(i));
         check("t4.cntle1", 32'(o_count <= 3'd1), 32'd1);
      end
      cycle(0, 0, 0, 1, 0, "t4.drain");
      check("t4.dropcnt", 32'(o_drop_cnt), 32'd1);

      // Sticky accumulation and clear.
      cycle(0, 0, 0, 1, 1, "t5.clr");
      cycle(1, 0, 4'b0001, 1, 0, "t5.s1");
      cycle(1, 0, 4'b0100, 1, 0, "t5.s2");
      check("t5.or", 32'(o_sticky), 32'h5);
      cycle(1, 0, 4'b1000, 1, 1, "t5.clrnew");
      check("t5.keepnew", 32'(o_sticky), 32'h8);
      cycle(0, 0, 0, 1, 1, "t5.clronly");
      check("t5.zero", 32'(o_sticky), 32'h0);

      // Asynchronous reset with 3 entries and two drops recorded.
      #2 rsn = 1'b0;
      #1 model_reset();
      rsn = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 1; i <= 4; i++) cycle(1, 4'(i), 4'(i), 0, 0, "t6.fill");
      cycle(1, 4'd7, 0, 0, 0, "t6.drop1");
      cycle(1, 4'd7, 0, 0, 0, "t6.drop2");
      cycle(0, 0, 0, 1, 0, "t6.pop");
      check("t6.cnt3", 32'(o_count), 32'd3);
      check("t6.dropcnt2", 32'(o_drop_cnt), 32'd2);
      #2 rsn = 1'b0;
      #1 model_reset();
      check_all("t6.arst");
      check("t6.arst.valid0", 32'(o_valid), 32'd0);
      check("t6.arst.cnt0", 32'(o_drop_cnt), 32'd0);
      #3 rsn = 1'b1;
      @(posedge clk);
      #1 check_all("t6.release");
      cycle(1, 4'd6, 4'd3, 1, 0, "t6.firstpush");

      // Drop counter saturation.
      for (int i = 0; i < 4; i++) cycle(1, 4'(i), 0, 0, 0, "t7.fill");
      for (int i = 0; i < 260; i++) cycle(1, 4'hf, 0, 0, 0, "t7.sat");
      check("t7.sat255", 32'(o_drop_cnt), 32'd255);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom),
               1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
